// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: power-up, pacing and read-out sequencer for an 8-bit parallel ADC.
// Drives PD/AD_CLK/S_H/CS_RD_n and hands each sample downstream on a valid/ready port.
module adc_sample_ctrl #(
    parameter int SAMPLE_DIV   = 200,
    parameter int SH_CYCLES    = 4,
    parameter int CONV_TIMEOUT = 40,
    parameter int ADCLK_DIV    = 2,
    parameter int WAKE_CYCLES  = 100
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [7:0] AD,
    input  logic       EOC_n,
    output logic       PD,
    output logic       CS_RD_n,
    output logic       AD_CLK,
    output logic       S_H,
    output logic [7:0] sample_data,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       overrun,
    output logic       conv_timeout
);
    localparam int PW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SMAX_A = (WAKE_CYCLES > CONV_TIMEOUT) ? WAKE_CYCLES : CONV_TIMEOUT;
    localparam int SMAX   = (SMAX_A > SH_CYCLES) ? SMAX_A : SH_CYCLES;
    localparam int SW     = $clog2(SMAX + 1);
    localparam int AW     = $clog2(ADCLK_DIV + 1);

    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] WAKE_LAST = SW'(WAKE_CYCLES - 1);
    localparam logic [SW-1:0] SH_LAST   = SW'(SH_CYCLES - 1);
    localparam logic [SW-1:0] TO_LAST   = SW'(CONV_TIMEOUT - 1);
    localparam logic [AW-1:0] ACLK_LAST = AW'(ADCLK_DIV - 1);

    typedef enum logic [2:0] {
        S_OFF, S_WAKE, S_IDLE, S_TRACK, S_CONV, S_READ1, S_READ2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] st_cnt_q, st_cnt_d;     // cycles spent in the current state
    logic [PW-1:0] per_cnt_q, per_cnt_d;   // sample-period phase
    logic [AW-1:0] aclk_cnt_q;
    logic          aclk_q;
    logic          eoc_meta_q, eoc_sync_q;
    logic          pd_q, sh_q, cs_rd_n_q;
    logic [7:0]    data_q;
    logic          valid_q, overrun_q, timeout_q;
    logic          timeout_d, sample_done_d;
    logic          period_tick;

    assign period_tick  = (per_cnt_q == PER_LAST);
    assign PD           = pd_q;
    assign S_H          = sh_q;
    assign CS_RD_n      = cs_rd_n_q;
    assign AD_CLK       = aclk_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign conv_timeout = timeout_q;

    // Two-flop synchroniser for the asynchronous end-of-conversion strobe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            eoc_meta_q <= 1'b1;
            eoc_sync_q <= 1'b1;
        end else begin
            eoc_meta_q <= EOC_n;
            eoc_sync_q <= eoc_meta_q;
        end
    end

    // Next-state logic; the period counter only runs once the converter is awake
    always_comb begin
        state_d       = state_q;
        timeout_d     = 1'b0;
        sample_done_d = 1'b0;
        per_cnt_d     = period_tick ? '0 : per_cnt_q + PW'(1);
        case (state_q)
            S_OFF: begin
                per_cnt_d = '0;
                if (en) state_d = S_WAKE;
            end
            S_WAKE: begin
                per_cnt_d = '0;
                if (st_cnt_q == WAKE_LAST) state_d = S_IDLE;
            end
            S_IDLE:  if (period_tick) state_d = S_TRACK;
            S_TRACK: if (st_cnt_q == SH_LAST) state_d = S_CONV;
            S_CONV: begin
                // A real EOC wins over a timeout landing on the same cycle
                if (!eoc_sync_q) begin
                    state_d = S_READ1;
                end else if (st_cnt_q == TO_LAST) begin
                    state_d   = S_READ1;
                    timeout_d = 1'b1;
                end
            end
            S_READ1: state_d = S_READ2;
            S_READ2: begin
                state_d       = S_IDLE;
                sample_done_d = 1'b1;
            end
            default: state_d = S_OFF;
        endcase
        if (!en) begin
            state_d       = S_OFF;
            per_cnt_d     = '0;
            timeout_d     = 1'b0;
            sample_done_d = 1'b0;
        end
        st_cnt_d = (state_d != state_q) ? '0 : st_cnt_q + SW'(1);
    end

    // State, counters and pin controls (pins registered from the next state)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_OFF;
            st_cnt_q  <= '0;
            per_cnt_q <= '0;
            pd_q      <= 1'b1;
            sh_q      <= 1'b0;
            cs_rd_n_q <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            st_cnt_q  <= st_cnt_d;
            per_cnt_q <= per_cnt_d;
            pd_q      <= (state_d == S_OFF);
            sh_q      <= (state_d == S_TRACK);
            cs_rd_n_q <= !((state_d == S_READ1) || (state_d == S_READ2));
            timeout_q <= timeout_d;
        end
    end

    // AD_CLK divider: low for the first half-period after power-up, held low while off
    always_ff @(posedge clk) begin
        if (!rstn) begin
            aclk_q     <= 1'b0;
            aclk_cnt_q <= '0;
        end else if ((state_q == S_OFF) || (state_d == S_OFF)) begin
            aclk_q     <= 1'b0;
            aclk_cnt_q <= '0;
        end else if (aclk_cnt_q == ACLK_LAST) begin
            aclk_q     <= ~aclk_q;
            aclk_cnt_q <= '0;
        end else begin
            aclk_cnt_q <= aclk_cnt_q + AW'(1);
        end
    end

    // Output handshake: load on READ2 completion unless an unaccepted sample is pending
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (sample_done_d) begin
                if (!valid_q || sample_ready) begin
                    data_q  <= AD;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_ctrl.sv
// tb_adc_sample_ctrl: randomized bench for adc_sample_ctrl with a timeline model of the
// sampling schedule and a per-cycle comparison of every output.
module tb_adc_sample_ctrl;
    localparam int SDIV = 200;
    localparam int SH   = 4;
    localparam int TO   = 40;
    localparam int ACD  = 2;
    localparam int WAKE = 100;
    localparam int NCYC = 12000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic [7:0] AD = 8'h00;
    logic       EOC_n = 1'b1;
    logic       sample_ready = 1'b0;
    logic       PD, CS_RD_n, AD_CLK, S_H, sample_valid, overrun, conv_timeout;
    logic [7:0] sample_data;

    adc_sample_ctrl #(
        .SAMPLE_DIV(SDIV), .SH_CYCLES(SH), .CONV_TIMEOUT(TO),
        .ADCLK_DIV(ACD), .WAKE_CYCLES(WAKE)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .AD(AD), .EOC_n(EOC_n),
        .PD(PD), .CS_RD_n(CS_RD_n), .AD_CLK(AD_CLK), .S_H(S_H),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun(overrun), .conv_timeout(conv_timeout)
    );

    always #5 clk = ~clk;

    // Inputs as presented during cycle c (sampled at the edge that starts cycle c+1)
    bit         in_rst [NCYC];
    bit         in_on  [NCYC];
    bit         in_eoc [NCYC];
    bit         in_rdy [NCYC];
    logic [7:0] in_ad  [NCYC];

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    // Model state
    int         t_on = -1;       // first powered cycle of the current enable run
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;

    // Stimulus controls
    int         eoc_d = 10;
    bit         eoc_tied = 1'b0;
    bit         rand_per = 1'b0;
    int         ad_mode = 0;
    logic [7:0] ad_fix = 8'h5A;
    int         rdy_mode = 0;
    int         tag = 0;

    // Observation of DUT pins for schedule-level checks
    logic prev_sh = 1'b0, prev_pd = 1'b1, prev_cs = 1'b1, prev_valid = 1'b0;
    int   pd_fall = 0, sh_rise = 0, sh_fall = 0, cs_fall = 0;
    bit   first_sh_pending = 1'b0;
    int   tmo_cnt = 0;
    int   ovr_cnt [8];
    int   drop_cnt [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // Cycle in which READ1 happens for the period whose S_H rise is at cycle p,
    // using only EOC history visible by cycle c; values > c mean "not yet".
    function automatic void read1_of(input int p, input int c, output int r, output bit tmo);
        r   = p + SH + TO;
        tmo = 1'b1;
        for (int n = p + SH; n <= p + SH + TO - 1; n++) begin
            if (n > c - 1) begin
                r   = c + 1000;
                tmo = 1'b0;
                return;
            end
            if (!in_eoc[n-2]) begin
                r   = n + 1;
                tmo = 1'b0;
                return;
            end
        end
    endfunction

    function automatic int phase_of(input int c);
        int d;
        if (t_on < 0) return -1;
        d = c - (t_on + WAKE);
        if (d < SDIV) return -1;
        return d % SDIV;
    endfunction

    task automatic model_and_check();
        int   c, d, ph, p, r;
        bit   on, tmo, cap, rdy;
        logic e_pd, e_cs, e_sh, e_ak, e_tm, e_ovr;
        c  = cyc;
        on = in_on[c-1];
        if (!on) t_on = -1;
        else if (t_on < 0) t_on = c;
        e_pd = !on; e_cs = 1'b1; e_sh = 1'b0; e_ak = 1'b0; e_tm = 1'b0; cap = 1'b0;
        if (on) begin
            e_ak = (((c - t_on) / ACD) % 2) == 1;
            d    = c - (t_on + WAKE);
            if (d >= SDIV) begin
                ph   = d % SDIV;
                p    = c - ph;
                e_sh = (ph < SH);
                read1_of(p, c, r, tmo);
                e_cs = !((c == r) || (c == r + 1));
                e_tm = tmo && (c == r);
            end
            if (d - 2 >= SDIV) begin
                ph = (d - 2) % SDIV;
                p  = c - 2 - ph;
                read1_of(p, c - 2, r, tmo);
                cap = (r == c - 2);
            end
        end
        rdy   = in_rdy[c-1];
        e_ovr = 1'b0;
        if (!in_rst[c-1]) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
        end else if (cap) begin
            if (!exp_valid || rdy) begin
                exp_data  = in_ad[c-1];
                exp_valid = 1'b1;
            end else begin
                e_ovr = 1'b1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        chk("PD", PD, e_pd);
        chk("CS_RD_n", CS_RD_n, e_cs);
        chk("S_H", S_H, e_sh);
        chk("AD_CLK", AD_CLK, e_ak);
        chk("conv_timeout", conv_timeout, e_tm);
        chk("overrun", overrun, e_ovr);
        chk("sample_valid", sample_valid, exp_valid);
        chk("sample_data", sample_data, exp_data);

        // Schedule-level literals measured from the pins
        if (!PD && prev_pd) begin
            pd_fall          = c;
            first_sh_pending = 1'b1;
        end
        if (S_H && !prev_sh) begin
            if (first_sh_pending) chk("wake_to_first_sh", c - pd_fall, 300);
            else chk("sh_rise_spacing", c - sh_rise, 200);
            first_sh_pending = 1'b0;
            sh_rise = c;
        end
        if (!S_H && prev_sh) begin
            chk("sh_width", c - sh_rise, 4);
            sh_fall = c;
        end
        if (!CS_RD_n && prev_cs) cs_fall = c;
        if (CS_RD_n && !prev_cs) chk("cs_low_width", c - cs_fall, 2);
        if (conv_timeout === 1'b1 && tag == 2) begin
            tmo_cnt++;
            chk("tmo_after_sh_fall", c - sh_fall, 40);
        end
        if (overrun === 1'b1) ovr_cnt[tag]++;
        if (!sample_valid && prev_valid) drop_cnt[tag]++;
        prev_sh = S_H; prev_pd = PD; prev_cs = CS_RD_n; prev_valid = sample_valid;
    endtask

    task automatic step();
        if (cyc >= NCYC - 2) begin
            n_err++;
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
            $display("Result: errors=%0d of %0d checks", n_err, n_checks);
            $fatal(1, "cycle budget exhausted");
        end
        in_rst[cyc] = rstn;
        in_on[cyc]  = rstn && en;
        in_eoc[cyc] = EOC_n;
        in_ad[cyc]  = AD;
        in_rdy[cyc] = sample_ready;
        @(posedge clk);
        cyc++;
        #1;
        model_and_check();
    endtask

    task automatic drive();
        int ph, p, r;
        bit tmo;
        ph = phase_of(cyc);
        if (rand_per && ph == 0) eoc_d = int'($urandom_range(49)) - 4;
        EOC_n = 1'b1;
        if (!eoc_tied && ph >= 0 && ph >= SH + eoc_d && ph < SH + eoc_d + 6) EOC_n = 1'b0;
        case (ad_mode)
            0:       AD = ad_fix;
            1:       AD = 8'(cyc);
            default: AD = 8'($urandom);
        endcase
        case (rdy_mode)
            0: sample_ready = 1'b1;
            1: sample_ready = 1'b0;
            2: begin
                sample_ready = 1'b0;
                if (ph >= 0) begin
                    p = cyc - ph;
                    read1_of(p, cyc, r, tmo);
                    if (r == cyc - 1) sample_ready = 1'b1;
                end
            end
            default: sample_ready = 1'($urandom_range(1));
        endcase
    endtask

    // Run until n more sample periods have finished (phase 60 is past any read-out)
    task automatic run_periods(input int n);
        int done;
        done = 0;
        while (done < n) begin
            drive();
            step();
            if (phase_of(cyc) == 60) done++;
        end
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            in_eoc[i] = 1'b1;
            in_rst[i] = 1'b0;
            in_on[i]  = 1'b0;
            in_rdy[i] = 1'b0;
            in_ad[i]  = 8'h00;
        end
        for (int i = 0; i < 8; i++) begin
            ovr_cnt[i]  = 0;
            drop_cnt[i] = 0;
        end

        // Reset held with en high
        rstn = 1'b0; en = 1'b1; sample_ready = 1'b1;
        repeat (4) step();
        rstn = 1'b1;

        // Normal acquisition, EOC 10 cycles after S_H falls, fixed data
        tag = 1; eoc_d = 10; ad_mode = 0; ad_fix = 8'h5A; rdy_mode = 0;
        run_periods(3);
        chk("normal_data", sample_data, 8'h5A);

        // EOC never asserts; AD ramps every clock
        tag = 2; eoc_tied = 1'b1; ad_mode = 1;
        run_periods(3);
        chk("timeout_count", tmo_cnt, 3);

        // Backpressure for three periods, then release
        tag = 3; eoc_tied = 1'b0; eoc_d = 10; ad_mode = 2; rdy_mode = 1;
        run_periods(3);
        chk("bp_overruns", ovr_cnt[3], 2);
        tag = 6; rdy_mode = 0;
        drive();
        step();
        chk("bp_release_valid", sample_valid, 1'b0);
        run_periods(1);

        // Accept and reload on the same edge
        tag = 4; rdy_mode = 1;
        run_periods(1);
        rdy_mode = 2;
        run_periods(2);
        chk("simul_overruns", ovr_cnt[4], 0);
        chk("simul_valid_drops", drop_cnt[4], 0);
        tag = 0; rdy_mode = 0;
        run_periods(1);

        // Abort during conversion with a pending sample, then re-enable
        tag = 5; rdy_mode = 1; eoc_d = 30;
        run_periods(1);
        while (phase_of(cyc) != 9) begin
            drive();
            step();
        end
        en = 1'b0;
        drive();
        step();
        chk("abort_pd", PD, 1'b1);
        chk("abort_cs", CS_RD_n, 1'b1);
        chk("abort_valid_kept", sample_valid, 1'b1);
        repeat (9) begin
            drive();
            step();
        end
        en = 1'b1; rdy_mode = 0;
        run_periods(2);

        // Randomized EOC timing, data and ready
        tag = 0; rand_per = 1'b1; ad_mode = 2; rdy_mode = 3;
        run_periods(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
